// File: rtl/antares_idex_register_pkg.sv
// Shared constants for the Antares ID/EX pipeline register.
package antares_idex_register_pkg;

    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned ALU_OP_WIDTH = 5;

    // ALU operation encodings; NOP must stay at zero so a cleared bundle is a bubble.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SHF = 5'd6;

    localparam logic SHIFT_DIR_RIGHT = 1'b0;
    localparam logic SHIFT_DIR_LEFT  = 1'b1;

endpackage

// File: rtl/antares_pipe_reg.sv
// Generic pipeline register: async active-low reset, flush loads CLEAR_VALUE, stall holds.
module antares_pipe_reg #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      CLEAR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Flush has priority over stall; otherwise capture d every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= CLEAR_VALUE;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/antares_idex_register.sv
// ID/EX pipeline register: operands, resolved shift controls and EX control fields.
module antares_idex_register
    import antares_idex_register_pkg::*;
#(
    parameter int unsigned ALU_OP_W = ALU_OP_WIDTH,
    parameter int unsigned GPR_AW   = GPR_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         id_data_rs,
    input  logic [31:0]         id_data_rt,
    input  logic [4:0]          id_shamt,
    input  logic                id_shift_variable,
    input  logic                id_shift_direction,
    input  logic                id_shift_sign_extend,
    input  logic [ALU_OP_W-1:0] id_alu_operation,
    input  logic [GPR_AW-1:0]   id_gpr_wa,
    input  logic                id_gpr_we,
    input  logic [31:0]         id_exception_pc,
    input  logic                id_delay_slot,
    input  logic                id_valid,
    input  logic                id_stall,
    input  logic                id_flush,
    input  logic                ex_stall,
    input  logic                ex_flush,
    output logic [31:0]         ex_data_rs,
    output logic [31:0]         ex_data_rt,
    output logic [31:0]         ex_shift_input_data,
    output logic [4:0]          ex_shift_shamnt,
    output logic                ex_shift_direction,
    output logic                ex_shift_sign_extend,
    output logic [ALU_OP_W-1:0] ex_alu_operation,
    output logic [GPR_AW-1:0]   ex_gpr_wa,
    output logic                ex_gpr_we,
    output logic [31:0]         ex_exception_pc,
    output logic                ex_delay_slot,
    output logic                ex_valid
);

    localparam int unsigned CTRL_W = ALU_OP_W + 5;
    localparam int unsigned DATA_W = 32 + 32 + 5 + GPR_AW + 32;

    // Cleared control bundle is a NOP: no writeback, not valid, right shift, no sign extend.
    localparam logic [CTRL_W-1:0] CTRL_CLEAR = {ALU_OP_W'(ALU_OP_NOP), SHIFT_DIR_RIGHT, 4'b0000};

    logic [4:0]        shamt_resolved;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              ctrl_clear;
    logic              data_hold;

    // Shift amount resolved before the register; only rs[4:0] counts for variable shifts.
    always_comb begin
        shamt_resolved = id_shift_variable ? id_data_rs[4:0] : id_shamt;
    end

    // Control clears on ex_flush, or on an ID bubble when EX is free to advance;
    // data holds on either ex_flush or ex_stall so EPC survives a squash.
    always_comb begin
        ctrl_clear = ex_flush | (~ex_stall & (id_stall | id_flush));
        data_hold  = ex_stall | ex_flush;
        ctrl_d     = {id_alu_operation, id_shift_direction, id_shift_sign_extend,
                      id_delay_slot, id_gpr_we, id_valid};
        data_d     = {id_data_rs, id_data_rt, shamt_resolved, id_gpr_wa, id_exception_pc};
    end

    antares_pipe_reg #(
        .WIDTH       (CTRL_W),
        .CLEAR_VALUE (CTRL_CLEAR)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (ex_stall),
        .flush (ctrl_clear),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    antares_pipe_reg #(
        .WIDTH       (DATA_W),
        .CLEAR_VALUE ('0)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (data_hold),
        .flush (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    // Unpack registered bundles; shifter data input shares the rt flops.
    always_comb begin
        {ex_alu_operation, ex_shift_direction, ex_shift_sign_extend,
         ex_delay_slot, ex_gpr_we, ex_valid} = ctrl_q;
        {ex_data_rs, ex_data_rt, ex_shift_shamnt, ex_gpr_wa, ex_exception_pc} = data_q;
        ex_shift_input_data = ex_data_rt;
    end

endmodule
